// File: rtl/rdid_pkg.sv
// Shared constants, state encoding and ID payload type for the RDID responder.
package rdid_pkg;

  localparam int unsigned CMD_W      = 8;
  localparam int unsigned ID_W       = 24;
  localparam int unsigned CMD_CNT_W  = 3;
  localparam int unsigned DATA_CNT_W = 5;
  localparam int unsigned ARM_CNT_W  = 3;

  localparam logic [CMD_W-1:0] RDID_CMD     = 8'h9F;
  localparam logic [7:0]       DEF_MAN_ID   = 8'h20;
  localparam logic [7:0]       DEF_MEM_TYPE = 8'h20;
  localparam logic [7:0]       DEF_MEM_CAP  = 8'h15;

  // CS must read high this many cycles before a falling edge may open a transaction.
  localparam logic [ARM_CNT_W-1:0] ARM_CYCLES = 3'd4;

  typedef struct packed {
    logic [7:0] man_id;
    logic [7:0] mem_type;
    logic [7:0] mem_cap;
  } jedec_id_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    RESP  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Five ASCII characters, for display as a string in waveform viewers.
  function automatic logic [39:0] state_name(input state_t s);
    case (s)
      IDLE:    state_name = "IDLE ";
      CMD:     state_name = "CMD  ";
      RESP:    state_name = "RESP ";
      default: state_name = "DRAIN";
    endcase
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchronizer for one SPI pin plus a registered edge detector.
module spi_pin_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;

  // level is the edge register, so it already shows the new value when a strobe fires.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta  <= RST_VAL;
      sync  <= RST_VAL;
      level <= RST_VAL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      meta  <= pin;
      sync  <= meta;
      level <= sync;
      rise  <= sync & ~level;
      fall  <= ~sync & level;
    end
  end

endmodule

// File: rtl/rdid_responder.sv
// SPI-slave model of the M25P16 RDID (0x9F) response, oversampling the flash-side pins.
module rdid_responder
  import rdid_pkg::*;
#(
  parameter logic [7:0] MAN_ID   = DEF_MAN_ID,
  parameter logic [7:0] MEM_TYPE = DEF_MEM_TYPE,
  parameter logic [7:0] MEM_CAP  = DEF_MEM_CAP
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spisck,
  input  logic       spimosi,
  input  logic       prom_cs_n,
  output logic       spimiso,
  output logic       cmd_valid,
  output logic [7:0] cmd_byte,
  output logic       rdid_done,
  output logic       busy
);

  localparam jedec_id_t ID_WORD = '{man_id: MAN_ID, mem_type: MEM_TYPE, mem_cap: MEM_CAP};

  logic       sck_level, sck_rise, sck_fall;
  logic       mosi_level;
  logic [1:0] unused_mosi_edges;
  logic       cs_level, cs_rise, cs_fall;

  spi_pin_sync #(.RST_VAL(1'b0)) u_sck (
    .clk(clk), .rst(rst), .pin(spisck),
    .level(sck_level), .rise(sck_rise), .fall(sck_fall)
  );

  spi_pin_sync #(.RST_VAL(1'b0)) u_mosi (
    .clk(clk), .rst(rst), .pin(spimosi),
    .level(mosi_level), .rise(unused_mosi_edges[1]), .fall(unused_mosi_edges[0])
  );

  spi_pin_sync #(.RST_VAL(1'b1)) u_cs (
    .clk(clk), .rst(rst), .pin(prom_cs_n),
    .level(cs_level), .rise(cs_rise), .fall(cs_fall)
  );

  state_t                  state_q, state_d;
  logic [CMD_CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DATA_CNT_W-1:0]   data_cnt_q, data_cnt_d;
  logic [CMD_W-1:0]        cmd_sh_q, cmd_sh_d;
  logic [ID_W-1:0]         id_sh_q, id_sh_d;
  logic [ARM_CNT_W-1:0]    arm_cnt_q, arm_cnt_d;
  logic                    miso_d, cmd_valid_d, rdid_done_d, busy_d;
  logic [CMD_W-1:0]        cmd_byte_d, cmd_next;
  logic                    sck_rise_act, sck_fall_act, armed;

  // SCK strobes only count while the synchronized chip select is low.
  assign sck_rise_act = sck_rise & ~cs_level & ~sck_level ^ sck_rise & ~cs_level;
  assign sck_fall_act = sck_fall & ~cs_level;
  assign cmd_next     = {cmd_sh_q[CMD_W-2:0], mosi_level};
  // A CS already low at reset reads as a fall from the reset value; require real high time first.
  assign armed        = (arm_cnt_q == ARM_CYCLES);

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    data_cnt_d  = data_cnt_q;
    cmd_sh_d    = cmd_sh_q;
    id_sh_d     = id_sh_q;
    miso_d      = spimiso;
    cmd_byte_d  = cmd_byte;
    cmd_valid_d = 1'b0;
    rdid_done_d = 1'b0;

    if (!cs_level) begin
      arm_cnt_d = '0;
    end else if (!armed) begin
      arm_cnt_d = arm_cnt_q + ARM_CNT_W'(1);
    end else begin
      arm_cnt_d = arm_cnt_q;
    end

    if (cs_rise) begin
      state_d = IDLE;
      miso_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          miso_d = 1'b0;
          if (cs_fall && armed) begin
            bit_cnt_d = '0;
            state_d   = CMD;
          end
        end
        CMD: begin
          if (sck_rise_act) begin
            cmd_sh_d  = cmd_next;
            bit_cnt_d = bit_cnt_q + CMD_CNT_W'(1);
            if (bit_cnt_q == CMD_CNT_W'(CMD_W - 1)) begin
              cmd_byte_d  = cmd_next;
              cmd_valid_d = 1'b1;
              if (cmd_next == RDID_CMD) begin
                id_sh_d    = ID_WORD;
                data_cnt_d = '0;
                state_d    = RESP;
              end else begin
                state_d = DRAIN;
              end
            end
          end
        end
        RESP: begin
          if (sck_fall_act) begin
            miso_d  = id_sh_q[ID_W-1];
            id_sh_d = {id_sh_q[ID_W-2:0], 1'b0};
          end
          if (sck_rise_act) begin
            data_cnt_d = data_cnt_q + DATA_CNT_W'(1);
            if (data_cnt_q == DATA_CNT_W'(ID_W - 1)) begin
              rdid_done_d = 1'b1;
              miso_d      = 1'b0;
              state_d     = DRAIN;
            end
          end
        end
        default: begin
          miso_d = 1'b0;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      data_cnt_q <= '0;
      cmd_sh_q   <= '0;
      id_sh_q    <= '0;
      arm_cnt_q  <= '0;
      spimiso    <= 1'b0;
      cmd_valid  <= 1'b0;
      cmd_byte   <= '0;
      rdid_done  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      data_cnt_q <= data_cnt_d;
      cmd_sh_q   <= cmd_sh_d;
      id_sh_q    <= id_sh_d;
      arm_cnt_q  <= arm_cnt_d;
      spimiso    <= miso_d;
      cmd_valid  <= cmd_valid_d;
      cmd_byte   <= cmd_byte_d;
      rdid_done  <= rdid_done_d;
      busy       <= busy_d;
    end
  end

endmodule

// File: tb/tb_rdid_responder.sv
// Self-checking bench: a mode-0 SPI master reads the responder and compares against a reference model.
module tb_rdid_responder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       spisck = 1'b0;
  logic       spimosi = 1'b0;
  logic       prom_cs_n = 1'b1;
  logic       spimiso;
  logic       cmd_valid;
  logic [7:0] cmd_byte;
  logic       rdid_done;
  logic       busy;

  rdid_responder dut (
    .clk(clk), .rst(rst), .spisck(spisck), .spimosi(spimosi), .prom_cs_n(prom_cs_n),
    .spimiso(spimiso), .cmd_valid(cmd_valid), .cmd_byte(cmd_byte),
    .rdid_done(rdid_done), .busy(busy)
  );

  always #5 clk = ~clk;

  localparam logic [23:0] JEDEC = 24'h202015;

  int n_cmp = 0;
  int n_bad = 0;

  // Event counters sampled away from the active edge.
  int         n_cv = 0;
  int         n_done = 0;
  int         n_miso_hi = 0;
  logic [7:0] last_cmd = 8'h00;

  always @(negedge clk) begin
    if (cmd_valid) begin
      n_cv     <= n_cv + 1;
      last_cmd <= cmd_byte;
    end
    if (rdid_done) n_done <= n_done + 1;
    if (spimiso)   n_miso_hi <= n_miso_hi + 1;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sck_cycle(input logic mo, input int half, output logic mi);
    spimosi = mo;
    wait_clk(half);
    mi = spimiso;
    spisck = 1'b1;
    wait_clk(half);
    spisck = 1'b0;
  endtask

  // Reference model: the master sees the ID bits MSB first only after a 0x9F, then zeros.
  function automatic logic [31:0] model_rx(input logic [7:0] cmd, input int ndata);
    logic [31:0] stream;
    stream = {JEDEC, 8'h00};
    if (cmd != 8'h9F || ndata == 0) return 32'h0;
    return stream >> (32 - ndata);
  endfunction

  function automatic logic model_done(input logic [7:0] cmd, input int ndata);
    return (cmd == 8'h9F) && (ndata >= 24);
  endfunction

  task automatic xfer(input logic [7:0] cmd, input int ndata, input int half,
                      input logic [31:0] exp_rx, input logic exp_done, input string tag);
    int          cv0, done0, hi0;
    logic        b;
    logic [31:0] rx;
    cv0   = n_cv;
    done0 = n_done;
    hi0   = n_miso_hi;
    rx    = '0;
    prom_cs_n = 1'b0;
    wait_clk(half);
    chk({tag, " busy_in_txn"}, 32'(busy), 32'd1);
    for (int i = 0; i < 8; i++) sck_cycle(cmd[7-i], half, b);
    for (int i = 0; i < ndata; i++) begin
      sck_cycle(1'b0, half, b);
      rx = {rx[30:0], b};
    end
    wait_clk(half);
    prom_cs_n = 1'b1;
    wait_clk(10);
    chk({tag, " rx"}, rx, exp_rx);
    chk({tag, " cmd_valid_cnt"}, 32'(n_cv - cv0), 32'd1);
    chk({tag, " cmd_byte"}, {24'h0, last_cmd}, {24'h0, cmd});
    chk({tag, " rdid_done_cnt"}, 32'(n_done - done0), 32'(exp_done));
    chk({tag, " miso_after_cs"}, 32'(spimiso), 32'd0);
    chk({tag, " busy_after_cs"}, 32'(busy), 32'd0);
    if (cmd != 8'h9F) chk({tag, " miso_quiet"}, 32'(n_miso_hi - hi0), 32'd0);
  endtask

  typedef struct {
    logic [7:0]  cmd;
    int          ndata;
    int          half;
    logic [31:0] exp_rx;
    logic        exp_done;
  } vec_t;

  initial begin
    vec_t vecs[9];
    int   cv0, done0, hi0;
    logic b;

    // Reset with pins idle.
    wait_clk(3);
    chk("reset spimiso", 32'(spimiso), 32'd0);
    chk("reset cmd_valid", 32'(cmd_valid), 32'd0);
    chk("reset cmd_byte", 32'(cmd_byte), 32'd0);
    chk("reset rdid_done", 32'(rdid_done), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    rst = 1'b0;
    wait_clk(10);

    vecs[0] = '{8'h9F, 24, 5, 32'h00202015, 1'b1};
    vecs[1] = '{8'h03, 24, 6, 32'h00000000, 1'b0};
    vecs[2] = '{8'h9F, 12, 5, 32'h00000202, 1'b0};
    vecs[3] = '{8'h9F, 24, 5, 32'h00202015, 1'b1};
    vecs[4] = '{8'h9F, 32, 6, 32'h20201500, 1'b1};
    vecs[5] = '{8'h05,  8, 7, 32'h00000000, 1'b0};
    vecs[6] = '{8'h9F, 16, 5, 32'h00002020, 1'b0};
    vecs[7] = '{8'h9F,  3, 5, 32'h00000001, 1'b0};
    vecs[8] = '{8'h1F, 24, 5, 32'h00000000, 1'b0};
    for (int i = 0; i < 9; i++)
      xfer(vecs[i].cmd, vecs[i].ndata, vecs[i].half, vecs[i].exp_rx, vecs[i].exp_done,
           $sformatf("vec%0d", i));

    // Reset while CS is held low in the middle of the ID response.
    cv0 = n_cv;
    prom_cs_n = 1'b0;
    wait_clk(6);
    for (int i = 0; i < 8; i++) sck_cycle(((8'h9F >> (7 - i)) & 8'h01) != 0, 5, b);
    for (int i = 0; i < 5; i++) sck_cycle(1'b0, 5, b);
    chk("midresp busy_before_rst", 32'(busy), 32'd1);
    rst = 1'b1;
    wait_clk(1);
    rst = 1'b0;
    chk("midresp busy_after_rst", 32'(busy), 32'd0);
    chk("midresp miso_after_rst", 32'(spimiso), 32'd0);
    done0 = n_done;
    hi0   = n_miso_hi;
    wait_clk(8);
    for (int i = 0; i < 32; i++) sck_cycle(((8'h9F >> (i % 8)) & 8'h01) != 0, 5, b);
    chk("midresp no_cmd_valid", 32'(n_cv - cv0), 32'd1);
    chk("midresp no_done", 32'(n_done - done0), 32'd0);
    chk("midresp miso_quiet", 32'(n_miso_hi - hi0), 32'd0);
    chk("midresp busy_while_cs_low", 32'(busy), 32'd0);
    prom_cs_n = 1'b1;
    wait_clk(10);
    xfer(8'h9F, 24, 5, 32'h00202015, 1'b1, "after_rst");

    // Randomized transactions against the reference model.
    for (int i = 0; i < 16; i++) begin
      logic [7:0] cmd;
      int         nd, hf;
      cmd = ($urandom_range(0, 1) == 0) ? 8'h9F : 8'($urandom);
      nd  = $urandom_range(0, 32);
      hf  = $urandom_range(5, 8);
      xfer(cmd, nd, hf, model_rx(cmd, nd), model_done(cmd, nd), $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
